// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: DEPTH x DATA_W register file with one synchronous write port and
// two synchronous read ports (A/B), each with one cycle of read latency.
// Optional feature: define WRITE_BYPASS_EN for write-first forwarding. When it is
// undefined, a read in the same cycle as a write to the same register returns the old
// contents (read-first).
module reg_file_2r1w #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid
);

  logic [DATA_W-1:0] mem_q  [DEPTH];
  logic [DATA_W-1:0] mem_d  [DEPTH];
  logic [DATA_W-1:0] mem_rd [DEPTH];
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              rvalid_q,  rvalid_d;

  // Next storage state. Out-of-range addresses match no entry, and a hardwired
  // register 0 never accepts a write.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (we && (waddr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
        mem_d[i] = wdata;
      end
    end
  end

  // Read source: post-write state gives write-first forwarding, current state gives read-first
  always_comb begin
`ifdef WRITE_BYPASS_EN
    mem_rd = mem_d;
`else
    mem_rd = mem_q;
`endif
  end

  // DEPTH:1 selection for both ports; register 0 (when hardwired) and out-of-range read 0
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!((ZERO_REG != 0) && (i == 0))) begin
        if (raddr_a == ADDR_W'(i)) sel_a = mem_rd[i];
        if (raddr_b == ADDR_W'(i)) sel_b = mem_rd[i];
      end
    end
  end

  // Output registers: capture on re, otherwise hold data and drop rvalid
  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    rvalid_d  = re;
    if (re) begin
      rdata_a_d = sel_a;
      rdata_b_d = sel_b;
    end
  end

  // State registers with asynchronous clear of storage and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign rvalid  = rvalid_q;

endmodule
